// File: rtl/uart_tx_ctrl_if.sv
// Data-memory bus bundle between the core and the memory-mapped UART transmitter.
interface uart_tx_ctrl_if #(
    parameter int unsigned XLEN = 32
) ();
    logic [XLEN-1:0] mem_addr_i;
    logic            mem_read_en_i;
    logic [XLEN-1:0] mem_read_data_o;
    logic            mem_write_en_i;
    logic [XLEN-1:0] mem_write_data_i;

    modport master (
        output mem_addr_i,
        output mem_read_en_i,
        input  mem_read_data_o,
        output mem_write_en_i,
        output mem_write_data_i
    );

    modport slave (
        input  mem_addr_i,
        input  mem_read_en_i,
        output mem_read_data_o,
        input  mem_write_en_i,
        input  mem_write_data_i
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and programmable baud divider.
// Optional even-parity bit per frame when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'hA000_0000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd87
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    uart_tx_ctrl_if.slave   mem,
    output logic            tx_o
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_TXDATA = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_BAUD   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Bus decode
    logic        w_sel;
    logic [1:0]  w_off;
    logic        w_wr;
    logic        w_rd;
    logic        w_txdata_wr;
    logic        w_unused;

    assign w_sel       = (mem.mem_addr_i[31:4] == BASE_ADDR[31:4]);
    assign w_off       = mem.mem_addr_i[3:2];
    assign w_wr        = mem.mem_write_en_i & w_sel;
    assign w_rd        = mem.mem_read_en_i & w_sel;
    assign w_txdata_wr = w_wr && (w_off == OFF_TXDATA);
    assign w_unused    = ^{mem.mem_write_data_i[XLEN-1:16], mem.mem_addr_i[1:0]};

    // Control and baud registers
    logic        r_tx_en;
    logic [15:0] r_baud;
    logic        w_par_en;
`ifdef UART_TX_PARITY_EN
    logic        r_par_en;
    assign w_par_en = r_par_en;
`else
    assign w_par_en = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_tx_en <= 1'b0;
            r_baud  <= DIV_RESET;
`ifdef UART_TX_PARITY_EN
            r_par_en <= 1'b0;
`endif
        end else begin
            if (w_wr && (w_off == OFF_CTRL)) begin
                r_tx_en <= mem.mem_write_data_i[0];
`ifdef UART_TX_PARITY_EN
                r_par_en <= mem.mem_write_data_i[1];
`endif
            end
            if (w_wr && (w_off == OFF_BAUD)) begin
                r_baud <= mem.mem_write_data_i[15:0];
            end
        end
    end

    // TX FIFO
    logic [7:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push  = w_txdata_wr && !w_full;
    assign w_head  = r_fifo[r_rd_ptr];

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
            // A dropped byte wins over a same-cycle W1C
            if (w_txdata_wr && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_wr && (w_off == OFF_STATUS) && mem.mem_write_data_i[3]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wr_ptr] <= mem.mem_write_data_i[7:0];
    end

    // Transmit FSM
    state_t      r_state, w_state_n;
    logic        r_tx, w_tx_n;
    logic [7:0]  r_shift, w_shift_n;
    logic [15:0] r_cnt, w_cnt_n;
    logic [2:0]  r_bit_cnt, w_bit_cnt_n;
    logic [15:0] r_div, w_div_n;
    logic [15:0] w_div_eff;
    logic        w_bit_done;
    logic        w_can_start;
    logic        w_load;
`ifdef UART_TX_PARITY_EN
    logic        r_par_bit, w_par_bit_n;
    logic        r_par_on, w_par_on_n;
`endif

    assign w_div_eff   = (r_baud < 16'd2) ? 16'd2 : r_baud;
    assign w_bit_done  = (r_cnt == (r_div - 16'd1));
    assign w_can_start = r_tx_en && !w_empty;

    always_comb begin
        w_state_n   = r_state;
        w_tx_n      = r_tx;
        w_shift_n   = r_shift;
        w_cnt_n     = r_cnt + 16'd1;
        w_bit_cnt_n = r_bit_cnt;
        w_div_n     = r_div;
        w_load      = 1'b0;
        w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_bit_n = r_par_bit;
        w_par_on_n  = r_par_on;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                w_load  = w_can_start;
            end
            S_START: begin
                if (w_bit_done) begin
                    w_state_n   = S_DATA;
                    w_tx_n      = r_shift[0];
                    w_shift_n   = {1'b0, r_shift[7:1]};
                    w_cnt_n     = '0;
                    w_bit_cnt_n = '0;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_cnt_n = '0;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        if (r_par_on) begin
                            w_state_n = S_PARITY;
                            w_tx_n    = r_par_bit;
                        end else begin
                            w_state_n = S_STOP;
                            w_tx_n    = 1'b1;
                        end
`else
                        w_state_n = S_STOP;
                        w_tx_n    = 1'b1;
`endif
                    end else begin
                        w_tx_n      = r_shift[0];
                        w_shift_n   = {1'b0, r_shift[7:1]};
                        w_bit_cnt_n = r_bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_done) begin
                    w_state_n = S_STOP;
                    w_tx_n    = 1'b1;
                    w_cnt_n   = '0;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_done) begin
                    w_cnt_n = '0;
                    if (w_can_start) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_n = S_IDLE;
                        w_tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_tx_n    = 1'b1;
            end
        endcase
        // Frame start: pop head, snapshot divider (and parity mode) for the whole frame
        if (w_load) begin
            w_pop     = 1'b1;
            w_state_n = S_START;
            w_tx_n    = 1'b0;
            w_shift_n = w_head;
            w_div_n   = w_div_eff;
            w_cnt_n   = '0;
`ifdef UART_TX_PARITY_EN
            w_par_bit_n = ^w_head;
            w_par_on_n  = r_par_en;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_div     <= 16'd2;
`ifdef UART_TX_PARITY_EN
            r_par_bit <= 1'b0;
            r_par_on  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_n;
            r_tx      <= w_tx_n;
            r_shift   <= w_shift_n;
            r_cnt     <= w_cnt_n;
            r_bit_cnt <= w_bit_cnt_n;
            r_div     <= w_div_n;
`ifdef UART_TX_PARITY_EN
            r_par_bit <= w_par_bit_n;
            r_par_on  <= w_par_on_n;
`endif
        end
    end

    assign tx_o = r_tx;

    // Register read-back, one cycle latency, zero when not addressed
    logic [XLEN-1:0] w_status;
    logic [XLEN-1:0] w_rd_mux;
    logic [XLEN-1:0] r_rd_data;

    assign w_status = XLEN'({r_count, r_overflow, w_full, w_empty, (r_state != S_IDLE)});

    always_comb begin
        w_rd_mux = '0;
        case (w_off)
            OFF_CTRL:   w_rd_mux = XLEN'({w_par_en, r_tx_en});
            OFF_STATUS: w_rd_mux = w_status;
            OFF_BAUD:   w_rd_mux = XLEN'(r_baud);
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd ? w_rd_mux : '0;
        end
    end

    assign mem.mem_read_data_o = r_rd_data;

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Memory-mapped UART transmitter that answers the core's data-memory bus (`mem_*`) at `BASE_ADDR`. Byte stores to TXDATA are pushed into a TX FIFO. When CTRL.TX_EN is set, a baud-rate FSM drains the FIFO onto `tx_o` as 8N1 frames. Reads return CTRL, STATUS or BAUD one cycle after the request, in the same way the data memory returns loads.

## Interface
- `BASE_ADDR`, 32'hA000_0000, region base. Decode is `mem_addr_i[31:4] == BASE_ADDR[31:4]`; register offset is `mem_addr_i[3:2]`.
- `FIFO_DEPTH`, 16, TX FIFO entries (power of two, ≥2).
- `DIV_RESET`, 16'd87, reset value of BAUD (10 MHz / 115200).
- `clk_i` in 1: system clock.
- `resetn_i` in 1: asynchronous, active-low reset.
- `mem_addr_i` in `XLEN`: byte address from the core.
- `mem_read_en_i` in 1: read request.
- `mem_read_data_o` out `XLEN`: registered read data.
- `mem_write_en_i` in 1: write request.
- `mem_write_data_i` in `XLEN`: write data. Only the bits listed per register are used.
- `tx_o` out 1: serial line, idle high.

## Operation
- Register map (word offsets):
  - 0x0 CTRL, RW. Bit0 is TX_EN.
  - 0x4 TXDATA, WO. A write pushes `mem_write_data_i[7:0]`.
  - 0x8 STATUS, RO except bit3. Fields: [0] busy, [1] fifo_empty, [2] fifo_full, [3] overflow (W1C), [8:4] fifo_count.
  - 0xC BAUD, RW. Bits [15:0] are DIV.
- Unselected or unused bits read 0. Writes to unselected addresses are ignored.
- A TXDATA write when the FIFO is full drops the byte and sets overflow. overflow stays set until software writes 1 to STATUS bit3.
- A push and a pop in the same cycle leave fifo_count unchanged. The pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when configured).
  - IDLE → START when TX_EN=1 and the FIFO is not empty. On this transition the FSM pops the FIFO head into a shift register and latches DIV. A DIV value below 2 is used as 2.
  - START → DATA after DIV clocks.
  - DATA shifts LSB first, one bit per DIV clocks, and counts 8 bits before leaving the state.
  - DATA → STOP after 8 bits.
  - After the STOP bit's DIV clocks, the FSM goes to START if TX_EN=1 and the FIFO is not empty, popping in the same cycle. Otherwise it goes to IDLE.
- busy = (state != IDLE).
- Clearing TX_EN mid-frame completes the current frame; no new frame starts.
- A BAUD write mid-frame takes effect at the next START.

## Timing
- Reset values: `tx_o`=1, `mem_read_data_o`=0, CTRL=0, BAUD=`DIV_RESET`, FIFO empty, overflow=0, state IDLE.
- Reset is asynchronous. Asserting `resetn_i` mid-frame forces `tx_o` high immediately and discards all FIFO contents.
- Read latency is 1 cycle. A read sampled at edge N drives `mem_read_data_o` after edge N.
- `mem_read_data_o` is 0 in any cycle following no read or an unselected read.
- A write to TXDATA at edge N updates fifo_count at edge N.
- If the FSM is IDLE with TX_EN=1, the pop occurs and `tx_o` falls at edge N+1.
- Frame length is 10·DIV clocks, or 11·DIV with parity. Back-to-back frames have no idle gap.
- A write to CTRL setting TX_EN at edge N lets the FSM start at edge N+1.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: adds a PARITY state between DATA and STOP, lasting DIV clocks, carrying even parity (XOR of the 8 data bits). CTRL bit1 (PAR_EN, reset 0) selects whether PARITY is used per frame, latched at START.
  - Undefined: no PARITY state. CTRL bit1 reads 0 and ignores writes.

## Test plan
- DIV=4, TX_EN=1, write 0x48 ('H') to 0xA000_0004:
  - `tx_o` is 0 for 4 clocks (start bit).
  - Data bits follow at 4 clocks each: 0,0,0,1,0,0,1,0.
  - Then 1 for 4 clocks (stop bit).
  - Total 40 clocks; busy is 1 throughout and 0 afterwards.
- TX_EN=0, write the 12 bytes of "Hello World!", then write CTRL=1:
  - STATUS reads count=12, empty=0 before the enable.
  - The 12 frames go out back-to-back with no gap, in order.
  - Afterwards STATUS = 0x002.
- TX_EN=0, write 17 bytes:
  - STATUS reads count=16, full=1, overflow=1.
  - Enabling sends the first 16 bytes only.
  - Writing 0x8 to STATUS clears overflow.
- Read BAUD at edge N: `mem_read_data_o` = 87 after N and 0 the following cycle. A read at 0xB000_0008 returns 0.
- Assert `resetn_i`=0 mid-data-bit while the FIFO holds 3 bytes: `tx_o`=1 immediately, STATUS = 0x002 after release, and no further frames are sent.
- With `UART_TX_PARITY_EN` and PAR_EN=1, DIV=4, write 0x48: a parity bit of 0 appears after data bit 7, and the frame lasts 44 clocks. With 0x49 the parity bit is 1.
